// File: rtl/pipe_reg_stage.sv
// -----------------------------------------------------------------------------
// pipe_reg_stage: one valid/data register slot of the elastic pipeline.
//
// Handshake: a beat moves from the upstream slot into this one on a clock edge
// when `advance` is high. `advance` is produced by the parent from the
// downstream chain (advance = !valid || downstream advance), so this slot
// never drops or duplicates a beat; when `advance` is low it simply holds.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (clears valid; data per DATA_RESET)
//   flush     synchronous clear of the valid bit, data untouched
//   advance   this slot may load from upstream on the next edge
//   up_valid  valid bit offered by the upstream slot (or pipeline input)
//   up_data   data offered by the upstream slot (or pipeline input)
//   valid     registered valid bit of this slot
//   data      registered data of this slot
// -----------------------------------------------------------------------------
module pipe_reg_stage #(
    parameter int               WIDTH      = 8,
    parameter int               DATA_RESET = 1,
    parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             advance,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Data only loads on a real beat so bubbles never overwrite held data.
    logic load_data;
    assign load_data = !flush && advance && up_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (advance) begin
            valid <= up_valid;
        end
    end

    generate
        if (DATA_RESET != 0) begin : g_data_rst
            always_ff @(posedge clk) begin
                if (rst) begin
                    data <= RST_VAL;
                end else if (load_data) begin
                    data <= up_data;
                end
            end
        end else begin : g_data_norst
            // No reset on the data flop: rst only blocks a load in that cycle.
            always_ff @(posedge clk) begin
                if (!rst && load_data) begin
                    data <= up_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg: DEPTH-stage elastic register pipeline with valid/ready
// back-pressure, synchronous flush and an occupancy count.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready are both high. in_ready never looks at in_valid; out_valid
// and out_data are registered and hold steady while out_ready is low.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, highest priority
//   flush      synchronous clear of every valid bit (data left as is)
//   in_valid   upstream beat present
//   in_ready   pipeline accepts in_data this cycle
//   in_data    upstream data, WIDTH bits
//   out_valid  last stage holds a beat
//   out_ready  downstream accepts out_data this cycle
//   out_data   last-stage data register, WIDTH bits
//   count      number of valid stages, $clog2(DEPTH+1) bits
// -----------------------------------------------------------------------------
module pipe_reg #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 3,
    parameter int               DATA_RESET = 1,
    parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int COUNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_vec;
    logic [WIDTH-1:0] data_arr [DEPTH];
    logic [DEPTH:0]   adv;
    logic [COUNT_W-1:0] count_q;
    logic xfer_in;
    logic xfer_out;

    // Advance ripples from out_ready back towards the input: a stage moves
    // when it is empty or the stage after it moves. Kept in one process so
    // the chain is evaluated in order from the output side.
    always_comb begin
        adv        = '0;
        adv[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = !valid_vec[i] || adv[i+1];
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic             up_v;
            logic [WIDTH-1:0] up_d;
            if (i == 0) begin : g_first
                assign up_v = in_valid;
                assign up_d = in_data;
            end else begin : g_rest
                assign up_v = valid_vec[i-1];
                assign up_d = data_arr[i-1];
            end

            pipe_reg_stage #(
                .WIDTH      (WIDTH),
                .DATA_RESET (DATA_RESET),
                .RST_VAL    (RST_VAL)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .advance  (adv[i]),
                .up_valid (up_v),
                .up_data  (up_d),
                .valid    (valid_vec[i]),
                .data     (data_arr[i])
            );
        end
    endgenerate

    assign in_ready  = adv[0];
    assign out_valid = valid_vec[DEPTH-1];
    assign out_data  = data_arr[DEPTH-1];
    assign xfer_in   = in_valid && in_ready;
    assign xfer_out  = out_valid && out_ready;

    // Occupancy tracks transfers; flush empties the pipe even if a beat was
    // offered in the same cycle, while a concurrent output beat still counts
    // as delivered downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + COUNT_W'(xfer_in) - COUNT_W'(xfer_out);
        end
    end

    assign count = count_q;

    // The counter must always agree with the number of occupied stages.
    a_count_popcount : assert property (@(posedge clk) disable iff (rst)
        count_q == COUNT_W'($countones(valid_vec)));

endmodule

// File: tb/tb_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg: self-checking bench for pipe_reg.
//   dut_a: WIDTH=8,  DEPTH=3, DATA_RESET=1, RST_VAL=0xC3
//   dut_b: WIDTH=8,  DEPTH=3, DATA_RESET=0   (shares inputs with dut_a)
//   dut_c: WIDTH=16, DEPTH=1                  (shares inputs with dut_d)
//   dut_d: WIDTH=16, DEPTH=5
// Inputs change 1 time unit after each rising edge; outputs are observed on
// the falling edge, where the scoreboards push accepted beats and pop/compare
// delivered ones.
// -----------------------------------------------------------------------------
module tb_pipe_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit sb_en   = 1'b0;

    // 8-bit group (dut_a, dut_b)
    logic       rst8, flush8, in_valid8, out_ready8;
    logic [7:0] in_data8;
    logic       a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [7:0] a_out_data, b_out_data;
    logic [1:0] a_count, b_count;

    // 16-bit group (dut_c, dut_d)
    logic        rst16, flush16, in_valid16, out_ready16;
    logic [15:0] in_data16;
    logic        c_in_ready, c_out_valid, d_in_ready, d_out_valid;
    logic [15:0] c_out_data, d_out_data;
    logic [0:0]  c_count;
    logic [2:0]  d_count;

    logic [7:0]  exp_a_q[$];
    logic [7:0]  exp_b_q[$];
    logic [15:0] exp_c_q[$];
    logic [15:0] exp_d_q[$];
    logic [7:0]  ea, eb;
    logic [15:0] ec, ed;
    logic        stall_c, stall_d;
    logic [15:0] hold_c, hold_d;

    pipe_reg #(.WIDTH(8), .DEPTH(3), .DATA_RESET(1), .RST_VAL(8'hC3)) dut_a (
        .clk(clk), .rst(rst8), .flush(flush8), .in_valid(in_valid8),
        .in_ready(a_in_ready), .in_data(in_data8), .out_valid(a_out_valid),
        .out_ready(out_ready8), .out_data(a_out_data), .count(a_count));

    pipe_reg #(.WIDTH(8), .DEPTH(3), .DATA_RESET(0)) dut_b (
        .clk(clk), .rst(rst8), .flush(flush8), .in_valid(in_valid8),
        .in_ready(b_in_ready), .in_data(in_data8), .out_valid(b_out_valid),
        .out_ready(out_ready8), .out_data(b_out_data), .count(b_count));

    pipe_reg #(.WIDTH(16), .DEPTH(1)) dut_c (
        .clk(clk), .rst(rst16), .flush(flush16), .in_valid(in_valid16),
        .in_ready(c_in_ready), .in_data(in_data16), .out_valid(c_out_valid),
        .out_ready(out_ready16), .out_data(c_out_data), .count(c_count));

    pipe_reg #(.WIDTH(16), .DEPTH(5)) dut_d (
        .clk(clk), .rst(rst16), .flush(flush16), .in_valid(in_valid16),
        .in_ready(d_in_ready), .in_data(in_data16), .out_valid(d_out_valid),
        .out_ready(out_ready16), .out_data(d_out_data), .count(d_count));

    // ---------------- scoreboards, 8-bit group ----------------
    always @(negedge clk) begin
        if (sb_en) begin
            if (rst8) begin
                exp_a_q.delete();
                exp_b_q.delete();
            end else begin
                n_tests++;
                if (a_count !== 2'(exp_a_q.size())) begin
                    n_fail++;
                    $display("FAIL sb_a_count: got %0d, required %0d", a_count, exp_a_q.size());
                end
                n_tests++;
                if (b_count !== 2'(exp_b_q.size())) begin
                    n_fail++;
                    $display("FAIL sb_b_count: got %0d, required %0d", b_count, exp_b_q.size());
                end
                if (a_out_valid && out_ready8) begin
                    n_tests++;
                    if (exp_a_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_a_unexpected: got %h, required no beat", a_out_data);
                    end else begin
                        ea = exp_a_q.pop_front();
                        if (a_out_data !== ea) begin
                            n_fail++;
                            $display("FAIL sb_a_data: got %h, required %h", a_out_data, ea);
                        end
                    end
                end
                if (b_out_valid && out_ready8) begin
                    n_tests++;
                    if (exp_b_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_b_unexpected: got %h, required no beat", b_out_data);
                    end else begin
                        eb = exp_b_q.pop_front();
                        if (b_out_data !== eb) begin
                            n_fail++;
                            $display("FAIL sb_b_data: got %h, required %h", b_out_data, eb);
                        end
                    end
                end
                if (flush8) begin
                    exp_a_q.delete();
                    exp_b_q.delete();
                end else begin
                    if (in_valid8 && a_in_ready) exp_a_q.push_back(in_data8);
                    if (in_valid8 && b_in_ready) exp_b_q.push_back(in_data8);
                end
            end
        end
    end

    // ---------------- scoreboards, 16-bit group ----------------
    always @(negedge clk) begin
        if (sb_en) begin
            if (rst16) begin
                exp_c_q.delete();
                exp_d_q.delete();
                stall_c = 1'b0;
                stall_d = 1'b0;
            end else begin
                n_tests++;
                if (c_count !== 1'(exp_c_q.size())) begin
                    n_fail++;
                    $display("FAIL sb_c_count: got %0d, required %0d", c_count, exp_c_q.size());
                end
                n_tests++;
                if (d_count !== 3'(exp_d_q.size())) begin
                    n_fail++;
                    $display("FAIL sb_d_count: got %0d, required %0d", d_count, exp_d_q.size());
                end
                if (stall_c) begin
                    n_tests++;
                    if (c_out_valid !== 1'b1 || c_out_data !== hold_c) begin
                        n_fail++;
                        $display("FAIL sb_c_hold: got v=%b d=%h, required v=1 d=%h", c_out_valid, c_out_data, hold_c);
                    end
                end
                if (stall_d) begin
                    n_tests++;
                    if (d_out_valid !== 1'b1 || d_out_data !== hold_d) begin
                        n_fail++;
                        $display("FAIL sb_d_hold: got v=%b d=%h, required v=1 d=%h", d_out_valid, d_out_data, hold_d);
                    end
                end
                if (c_out_valid && out_ready16) begin
                    n_tests++;
                    if (exp_c_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_c_unexpected: got %h, required no beat", c_out_data);
                    end else begin
                        ec = exp_c_q.pop_front();
                        if (c_out_data !== ec) begin
                            n_fail++;
                            $display("FAIL sb_c_data: got %h, required %h", c_out_data, ec);
                        end
                    end
                end
                if (d_out_valid && out_ready16) begin
                    n_tests++;
                    if (exp_d_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_d_unexpected: got %h, required no beat", d_out_data);
                    end else begin
                        ed = exp_d_q.pop_front();
                        if (d_out_data !== ed) begin
                            n_fail++;
                            $display("FAIL sb_d_data: got %h, required %h", d_out_data, ed);
                        end
                    end
                end
                stall_c = c_out_valid && !out_ready16 && !flush16;
                stall_d = d_out_valid && !out_ready16 && !flush16;
                hold_c  = c_out_data;
                hold_d  = d_out_data;
                if (flush16) begin
                    exp_c_q.delete();
                    exp_d_q.delete();
                end else begin
                    if (in_valid16 && c_in_ready) exp_c_q.push_back(in_data16);
                    if (in_valid16 && d_in_ready) exp_d_q.push_back(in_data16);
                end
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst8 = 1'b1; flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; in_data8 = '0;
        rst16 = 1'b1; flush16 = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b0; in_data16 = '0;
        tick();
        tick();
        @(negedge clk);
        n_tests++;
        if (a_out_valid !== 1'b0 || a_count !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_a: got v=%b cnt=%0d, required v=0 cnt=0", a_out_valid, a_count);
        end
        n_tests++;
        if (a_out_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL reset_a_data: got %h, required c3", a_out_data);
        end
        n_tests++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got a=%b b=%b, required 1 1", a_in_ready, b_in_ready);
        end
        n_tests++;
        if (b_out_valid !== 1'b0 || b_count !== 2'd0 || c_out_valid !== 1'b0 || d_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_bcd: got bv=%b bc=%0d cv=%b dc=%0d, required 0 0 0 0",
                     b_out_valid, b_count, c_out_valid, d_count);
        end
        tick();
        rst8 = 1'b0;
        rst16 = 1'b0;
        sb_en = 1'b1;
    endtask

    task automatic test_stream();
        int acc, del, exp_cnt;
        bit exp_v;
        for (int k = 0; k < 16; k++) begin
            in_valid8  = (k < 10);
            in_data8   = 8'(k + 1);
            out_ready8 = 1'b1;
            @(negedge clk);
            acc = (k < 10) ? k : 10;
            del = (k < 3) ? 0 : ((k - 3 > 10) ? 10 : k - 3);
            exp_cnt = acc - del;
            exp_v = (k >= 3) && (k <= 12);
            n_tests++;
            if (a_in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_in_ready k=%0d: got %b, required 1", k, a_in_ready);
            end
            n_tests++;
            if (a_out_valid !== exp_v || a_count !== 2'(exp_cnt)) begin
                n_fail++;
                $display("FAIL stream_state k=%0d: got v=%b cnt=%0d, required v=%b cnt=%0d",
                         k, a_out_valid, a_count, exp_v, exp_cnt);
            end
            if (exp_v) begin
                n_tests++;
                if (a_out_data !== 8'(k - 2)) begin
                    n_fail++;
                    $display("FAIL stream_data k=%0d: got %h, required %h", k, a_out_data, 8'(k - 2));
                end
            end
            tick();
        end
    endtask

    task automatic test_full_stall();
        out_ready8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid8 = 1'b1;
            in_data8  = 8'(8'h11 * (k + 1));
            @(negedge clk);
            n_tests++;
            if (a_in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_fill k=%0d: got in_ready=%b, required 1", k, a_in_ready);
            end
            tick();
        end
        in_valid8 = 1'b1;
        in_data8  = 8'h44;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (a_in_ready !== 1'b0 || a_count !== 2'd3 || a_out_valid !== 1'b1 || a_out_data !== 8'h11) begin
                n_fail++;
                $display("FAIL stall_full k=%0d: got rdy=%b cnt=%0d v=%b d=%h, required 0 3 1 11",
                         k, a_in_ready, a_count, a_out_valid, a_out_data);
            end
            tick();
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        @(negedge clk);
        n_tests++;
        if (a_count !== 2'd0 || a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain: got cnt=%0d v=%b, required 0 0", a_count, a_out_valid);
        end
        tick();
    endtask

    task automatic test_bubble();
        out_ready8 = 1'b0;
        in_valid8 = 1'b1; in_data8 = 8'hA0;
        tick();
        in_valid8 = 1'b0;
        tick();
        tick();
        in_valid8 = 1'b1; in_data8 = 8'hA1;
        tick();
        in_valid8 = 1'b0;
        tick();
        @(negedge clk);
        n_tests++;
        if (a_count !== 2'd2 || a_in_ready !== 1'b1 || a_out_valid !== 1'b1 || a_out_data !== 8'hA0) begin
            n_fail++;
            $display("FAIL bubble: got cnt=%0d rdy=%b v=%b d=%h, required 2 1 1 a0",
                     a_count, a_in_ready, a_out_valid, a_out_data);
        end
        n_tests++;
        if (b_out_data !== 8'hA0) begin
            n_fail++;
            $display("FAIL bubble_b: got %h, required a0", b_out_data);
        end
        tick();
        out_ready8 = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        @(negedge clk);
        n_tests++;
        if (a_count !== 2'd0) begin
            n_fail++;
            $display("FAIL bubble_drain: got cnt=%0d, required 0", a_count);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready8 = 1'b0;
        in_valid8 = 1'b1; in_data8 = 8'h61;
        tick();
        in_data8 = 8'h62;
        tick();
        flush8 = 1'b1; in_data8 = 8'h55;
        @(negedge clk);
        n_tests++;
        if (a_in_ready !== 1'b1 || a_count !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_pre: got rdy=%b cnt=%0d, required 1 2", a_in_ready, a_count);
        end
        tick();
        flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
        @(negedge clk);
        n_tests++;
        if (a_count !== 2'd0 || a_out_valid !== 1'b0 || b_count !== 2'd0) begin
            n_fail++;
            $display("FAIL flush_post: got cnt=%0d v=%b bcnt=%0d, required 0 0 0", a_count, a_out_valid, b_count);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            n_tests++;
            if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_ghost k=%0d: got av=%b bv=%b, required 0 0", k, a_out_valid, b_out_valid);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid8 = 1'b1;
            in_data8  = 8'(8'h71 + k);
            tick();
        end
        in_valid8 = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_count !== 2'd3 || a_out_data !== 8'h71 || b_out_data !== 8'h71) begin
            n_fail++;
            $display("FAIL rstmid_pre: got cnt=%0d a=%h b=%h, required 3 71 71", a_count, a_out_data, b_out_data);
        end
        tick();
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_out_valid !== 1'b0 || a_out_data !== 8'hC3 || a_count !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_a: got v=%b d=%h cnt=%0d, required 0 c3 0", a_out_valid, a_out_data, a_count);
        end
        n_tests++;
        if (b_out_valid !== 1'b0 || b_out_data !== 8'h71 || b_count !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_b: got v=%b d=%h cnt=%0d, required 0 71 0", b_out_valid, b_out_data, b_count);
        end
        tick();
    endtask

    task automatic test_random();
        int pv, pr;
        pv = 70; pr = 70;
        for (int k = 0; k < 10000; k++) begin
            if (k % 1000 == 0) begin
                pv = $urandom_range(20, 95);
                pr = $urandom_range(20, 95);
            end
            in_valid16  = ($urandom_range(0, 99) < pv);
            out_ready16 = ($urandom_range(0, 99) < pr);
            flush16     = ($urandom_range(0, 299) == 0);
            in_data16   = 16'($urandom_range(0, 65535));
            tick();
        end
        in_valid16 = 1'b0; flush16 = 1'b0; out_ready16 = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        @(negedge clk);
        n_tests++;
        if (c_count !== 1'd0 || d_count !== 3'd0 || exp_c_q.size() != 0 || exp_d_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got c=%0d d=%0d qc=%0d qd=%0d, required all 0",
                     c_count, d_count, exp_c_q.size(), exp_d_q.size());
        end
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_stream();
        test_full_stall();
        test_bubble();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
